nibble_deserializer: RTL
========================

# nibble_deserializer

Upstream stage of the nibble threshold classifier (the "less than two" / "at least two" detector). Accepts a serial bit stream, LSB first, and assembles 4-bit nibbles. It buffers completed nibbles in a 2-entry FIFO and presents them on a valid/ready interface. The classifier's 4-bit input is driven from nib_data whenever nib_valid && nib_ready.

## Interface
- NIB_W, 4, nibble width in bits; the classifier is 4 bits wide, and only 4 is supported.
- FIFO_DEPTH, 2, output buffer entries; must be a power of two and at least 2.
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset; asserting it clears all state immediately.
- bit_valid  input  1  bit_in is meaningful this cycle.
- bit_in  input  1  serial data bit, LSB of the nibble first.
- sof  input  1  start of frame; qualified by bit_valid; marks bit_in as bit 0 of a new nibble.
- bit_ready  output  1  block accepts a bit this cycle; a bit transfers on bit_valid && bit_ready.
- nib_valid  output  1  FIFO head is valid.
- nib_data  output  NIB_W  FIFO head nibble.
- nib_ready  input  1  consumer takes the head; a nibble transfers on nib_valid && nib_ready.
- nib_count  output  8  count of nibbles transferred out; wraps 255 -> 0.
- parity_err  output  1  one-cycle pulse when a parity check fails; present only with the macro defined, tied 0 otherwise.

## Operation
- Shift register `sh[NIB_W-1:0]` and bit index `idx` (0..NIB_W-1).
  - An accepted bit writes `sh[idx]` and increments `idx`.
- State machine states:
  - COLLECT: gathering data bits.
  - PARITY: waiting for the parity bit; exists only with the macro defined.
- Transitions:
  - COLLECT, accepted bit at idx == NIB_W-1: without parity, push `{bit_in, sh[NIB_W-2:0]}` into the FIFO, set idx = 0, and stay in COLLECT. With parity, go to PARITY.
  - PARITY, accepted bit: set idx = 0 and return to COLLECT. If parity matches, push the nibble; otherwise drop it and pulse parity_err.
- sof on an accepted bit:
  - Discards any partial nibble; in PARITY, the pending nibble is discarded with no push and no parity_err.
  - The bit becomes bit 0, idx becomes 1, and the state becomes COLLECT.
  - When NIB_W-1 earlier bits are pending, sof still restarts; it never completes the pending nibble.
- bit_ready = !fifo_full, combinational from the FIFO occupancy count.
  - When full, no bit is accepted and the shift state holds.
  - Bits that do not push are also blocked while full, which keeps the rule simple.
- FIFO behaviour:
  - Simultaneous push and pop is legal whenever not full, and occupancy is unchanged.
  - Pop when empty is impossible, because nib_valid = !empty.
- nib_count increments on every output transfer.

## Timing
- Reset values:
  - bit_ready = 1
  - nib_valid = 0
  - nib_data = 0
  - nib_count = 0
  - parity_err = 0
  - idx = 0, state = COLLECT, FIFO empty
- Latency: the last bit is accepted at edge N, and nib_valid is high in the cycle after edge N. nib_data is driven from the registered FIFO head.
- bit_ready falls in the cycle after the push that fills the FIFO. It rises in the cycle after the pop that frees an entry.
- parity_err is registered and high for exactly the one cycle after the failing bit's edge.
- Reset mid-nibble or mid-FIFO discards all contents; there are no partial outputs after reset is released.

## Configuration
- Macro: `NIBBLE_DESER_PARITY_EN`.
- Defined:
  - Each nibble is followed by one even-parity bit; the XOR of the nibble and the parity bit must be 0.
  - The PARITY state and the parity_err logic are present.
  - Throughput is 5 bits per nibble.
- Undefined:
  - There is no PARITY state, and parity_err is constant 0.
  - Throughput is 4 bits per nibble.

## Structure
- Shared package `nibble_pkg`:
  - NIB_W = 4.
  - The state enum `deser_state_t` {COLLECT, PARITY}.
  - The counter width constant NIB_CNT_W = 8.
- Sub-module `nibble_fifo`: parameterised on width and depth. It provides push/pop, full/empty, a registered head, and pointer wrap via power-of-two masking.

## Test plan
- Basic assembly: bits 0,1,0,0 with sof on the first bit, nib_ready = 1 -> nib_data = 4'b0010, nib_valid for 1 cycle, nib_count = 1.
- Backpressure: nib_ready = 0, send 12 bits for nibbles 4'hA, 4'h3, 4'hF -> bit_ready drops after the 2nd push and the third nibble stalls. Releasing nib_ready -> data in order A, 3, F and nib_count = 3.
- sof restart: send 1,1,1, then sof with bits 0,0,0,1 -> exactly one nibble, 4'b1000.
- Counter wrap: transfer 256 nibbles -> nib_count returns to 0.
- Reset mid-nibble: 2 bits sent, assert rst -> nib_valid = 0, bit_ready = 1. Next 4 bits 1,0,1,0 -> 4'h5.
- With `NIBBLE_DESER_PARITY_EN`, input nibble 4'h3:
  - Parity bit 0 -> nibble pushed.
  - Parity bit 1 -> no push, and parity_err pulses exactly 1 cycle.

Source files
------------

// File: rtl/nibble_pkg.sv
// Shared constants and types for the nibble deserializer and its output FIFO.
package nibble_pkg;

    localparam int unsigned NIB_W      = 4;
    localparam int unsigned NIB_CNT_W  = 8;
    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned IDX_W      = $clog2(NIB_W);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        PARITY  = 1'b1
    } deser_state_t;

endpackage

// File: rtl/nibble_fifo.sv
// Small power-of-two FIFO with a registered head word and occupancy-based full/empty.
module nibble_fifo #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [AW-1:0] PTR_MASK = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_inc;
    logic [AW-1:0]    wr_ptr_inc;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;
    logic [WIDTH-1:0] head_nxt;

    assign full       = (count == CW'(DEPTH));
    assign empty      = (count == '0);
    assign do_push    = push && !full;
    assign do_pop     = pop && !empty;
    assign rd_ptr_inc = (rd_ptr + AW'(1)) & PTR_MASK;
    assign wr_ptr_inc = (wr_ptr + AW'(1)) & PTR_MASK;

    // Next head: the entry behind the popped one, or a push landing in an empty slot.
    always_comb begin
        head_nxt = head;
        if (do_pop) begin
            if (count > CW'(1)) begin
                head_nxt = mem[rd_ptr_inc];
            end else if (do_push) begin
                head_nxt = push_data;
            end
        end else if (empty && do_push) begin
            head_nxt = push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            head <= head_nxt;
            if (do_push) begin
                wr_ptr <= wr_ptr_inc;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr_inc;
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/nibble_deserializer.sv
// Serial LSB-first bit stream to 4-bit nibbles, buffered in a small FIFO with valid/ready output.
// Optional even-parity bit per nibble enabled by defining NIBBLE_DESER_PARITY_EN.
module nibble_deserializer
    import nibble_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bit_valid,
    input  logic                 bit_in,
    input  logic                 sof,
    output logic                 bit_ready,
    output logic                 nib_valid,
    output logic [NIB_W-1:0]     nib_data,
    input  logic                 nib_ready,
    output logic [NIB_CNT_W-1:0] nib_count,
    output logic                 parity_err
);

    deser_state_t     state;
    deser_state_t     state_nxt;
    logic [NIB_W-1:0] sh;
    logic [NIB_W-1:0] sh_nxt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nxt;
    logic             push;
    logic [NIB_W-1:0] push_data;
    logic             full;
    logic             empty;
    logic             accept;
    logic             xfer;
`ifdef NIBBLE_DESER_PARITY_EN
    logic             perr_nxt;
`endif

    assign bit_ready = !full;
    assign nib_valid = !empty;
    assign accept    = bit_valid && bit_ready;
    assign xfer      = nib_valid && nib_ready;

    // Bit assembly and nibble completion; sof always restarts at bit 0.
    always_comb begin
        state_nxt = state;
        sh_nxt    = sh;
        idx_nxt   = idx;
        push      = 1'b0;
        push_data = {bit_in, sh[NIB_W-2:0]};
`ifdef NIBBLE_DESER_PARITY_EN
        perr_nxt  = 1'b0;
`endif
        if (accept) begin
            if (sof) begin
                sh_nxt    = '0;
                sh_nxt[0] = bit_in;
                idx_nxt   = IDX_W'(1);
                state_nxt = COLLECT;
            end else begin
                unique case (state)
                    COLLECT: begin
                        sh_nxt[idx] = bit_in;
                        if (idx == IDX_W'(NIB_W - 1)) begin
                            idx_nxt = '0;
`ifdef NIBBLE_DESER_PARITY_EN
                            state_nxt = PARITY;
`else
                            push = 1'b1;
`endif
                        end else begin
                            idx_nxt = idx + IDX_W'(1);
                        end
                    end
`ifdef NIBBLE_DESER_PARITY_EN
                    PARITY: begin
                        idx_nxt   = '0;
                        state_nxt = COLLECT;
                        if (^{sh, bit_in} == 1'b0) begin
                            push      = 1'b1;
                            push_data = sh;
                        end else begin
                            perr_nxt = 1'b1;
                        end
                    end
`endif
                    default: begin
                        state_nxt = COLLECT;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= COLLECT;
            sh        <= '0;
            idx       <= '0;
            nib_count <= '0;
        end else begin
            state <= state_nxt;
            sh    <= sh_nxt;
            idx   <= idx_nxt;
            if (xfer) begin
                nib_count <= nib_count + NIB_CNT_W'(1);
            end
        end
    end

`ifdef NIBBLE_DESER_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= perr_nxt;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    nibble_fifo #(
        .WIDTH (NIB_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (nib_ready),
        .full      (full),
        .empty     (empty),
        .head      (nib_data)
    );

endmodule
